// File: rtl/vga_draw_pkg.sv
// Shared types and helpers for the framebuffer drawing engine.
//   mode_t  : command encoding on MODE
//   state_t : engine sequencing states
//   fb_addr : packs (row, col) into the 13-bit framebuffer address
package vga_draw_pkg;

  localparam int unsigned FB_COLS = 80;
  localparam int unsigned FB_ROWS = 60;
  localparam int unsigned COL_W   = 7;
  localparam int unsigned ROW_W   = 6;
  localparam int unsigned ADDR_W  = ROW_W + COL_W;
  localparam int unsigned PIX_W   = 8;

  typedef enum logic [1:0] {
    MODE_FILL   = 2'b00,
    MODE_INVERT = 2'b01,
    MODE_CLEAR  = 2'b10,
    MODE_RSVD   = 2'b11
  } mode_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_INV_RD,
    ST_INV_WR,
    ST_FIN
  } state_t;

  // Framebuffer address is {row, col}; rows are 128 words apart.
  function automatic logic [ADDR_W-1:0] fb_addr(input logic [ROW_W-1:0] row,
                                                input logic [COL_W-1:0] col);
    return {row, col};
  endfunction

endpackage

// File: rtl/vga_rect_walker.sv
// Row-major rectangle scan counter.
//   clk_i/rst_i      : clock, synchronous active-high reset
//   load_i + bounds  : latch inclusive bounds, position <- (ymin, xmin)
//   step_i           : advance one pixel (col first, then row)
//   col_o/row_o      : current position
//   last_o           : current position is (ymax, xmax)
module vga_rect_walker
  import vga_draw_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [COL_W-1:0] xmin_i,
  input  logic [COL_W-1:0] xmax_i,
  input  logic [ROW_W-1:0] ymin_i,
  input  logic [ROW_W-1:0] ymax_i,
  input  logic             step_i,
  output logic [COL_W-1:0] col_o,
  output logic [ROW_W-1:0] row_o,
  output logic             last_o
);

  logic [COL_W-1:0] col_q, col_d, xmin_q, xmin_d, xmax_q, xmax_d;
  logic [ROW_W-1:0] row_q, row_d, ymin_q, ymin_d, ymax_q, ymax_d;

  // Bound and position registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      col_q  <= '0;
      row_q  <= '0;
      xmin_q <= '0;
      xmax_q <= '0;
      ymin_q <= '0;
      ymax_q <= '0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      xmin_q <= xmin_d;
      xmax_q <= xmax_d;
      ymin_q <= ymin_d;
      ymax_q <= ymax_d;
    end
  end

  // Load / step; row saturates at ymax so a step past the end never wraps
  always_comb begin
    col_d  = col_q;
    row_d  = row_q;
    xmin_d = xmin_q;
    xmax_d = xmax_q;
    ymin_d = ymin_q;
    ymax_d = ymax_q;
    if (load_i) begin
      xmin_d = xmin_i;
      xmax_d = xmax_i;
      ymin_d = ymin_i;
      ymax_d = ymax_i;
      col_d  = xmin_i;
      row_d  = ymin_i;
    end else if (step_i) begin
      if (col_q == xmax_q) begin
        col_d = xmin_q;
        if (row_q != ymax_q) row_d = row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end
  end

  assign col_o  = col_q;
  assign row_o  = row_q;
  assign last_o = (col_q == xmax_q) && (row_q == ymax_q);

endmodule

// File: rtl/vga_rect_engine.sv
// Rectangle fill / invert / clear engine that owns the framebuffer port.
//   CLK, RST            : clock, synchronous active-high reset
//   MCU_WA/WD/WE/RD     : MCU framebuffer access, passed through when idle
//   X0,X1,Y0,Y1,COLOR   : rectangle corners and colour
//   MODE, START         : command and one-cycle strobe
//   BUSY, DONE          : engine owns the port / one-cycle completion pulse
//   FB_WA/WD/WE, FB_RD  : framebuffer port (read data one cycle after address)
module vga_rect_engine
  import vga_draw_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  input  logic [ADDR_W-1:0] MCU_WA,
  input  logic [PIX_W-1:0]  MCU_WD,
  input  logic              MCU_WE,
  output logic [PIX_W-1:0]  MCU_RD,
  input  logic [COL_W-1:0]  X0,
  input  logic [COL_W-1:0]  X1,
  input  logic [ROW_W-1:0]  Y0,
  input  logic [ROW_W-1:0]  Y1,
  input  logic [PIX_W-1:0]  COLOR,
  input  logic [1:0]        MODE,
  input  logic              START,
  output logic              BUSY,
  output logic              DONE,
  output logic [ADDR_W-1:0] FB_WA,
  output logic [PIX_W-1:0]  FB_WD,
  output logic              FB_WE,
  input  logic [PIX_W-1:0]  FB_RD
);

  localparam logic [COL_W-1:0] XLIM = COL_W'(FB_COLS - 1);
  localparam logic [ROW_W-1:0] YLIM = ROW_W'(FB_ROWS - 1);

  state_t           state_q, state_d;
  mode_t            mode_q, mode_d, mode_in;
  logic [PIX_W-1:0] color_q, color_d;

  logic [COL_W-1:0] x0c, x1c, xmin, xmax, cur_col;
  logic [ROW_W-1:0] y0c, y1c, ymin, ymax, cur_row;
  logic             ld, step, last;
  logic             eng_we, busy_c, done_c;
  logic [PIX_W-1:0] eng_wd;

  assign mode_in = mode_t'(MODE);

  // Clamp, sort, and apply the full-screen override for CLEAR
  always_comb begin
    x0c  = (X0 > XLIM) ? XLIM : X0;
    x1c  = (X1 > XLIM) ? XLIM : X1;
    y0c  = (Y0 > YLIM) ? YLIM : Y0;
    y1c  = (Y1 > YLIM) ? YLIM : Y1;
    xmin = (x0c < x1c) ? x0c : x1c;
    xmax = (x0c < x1c) ? x1c : x0c;
    ymin = (y0c < y1c) ? y0c : y1c;
    ymax = (y0c < y1c) ? y1c : y0c;
    if (mode_in == MODE_CLEAR) begin
      xmin = '0;
      xmax = XLIM;
      ymin = '0;
      ymax = YLIM;
    end
  end

  vga_rect_walker u_walker (
    .clk_i  (CLK),
    .rst_i  (RST),
    .load_i (ld),
    .xmin_i (xmin),
    .xmax_i (xmax),
    .ymin_i (ymin),
    .ymax_i (ymax),
    .step_i (step),
    .col_o  (cur_col),
    .row_o  (cur_row),
    .last_o (last)
  );

  // State and latched command
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_FILL;
      color_q <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      color_q <= color_d;
    end
  end

  // Next state and engine port drive
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    color_d = color_q;
    ld      = 1'b0;
    step    = 1'b0;
    eng_we  = 1'b0;
    eng_wd  = color_q;
    busy_c  = 1'b0;
    done_c  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (START) begin
          mode_d  = mode_in;
          color_d = COLOR;
          ld      = 1'b1;
          unique case (mode_in)
            MODE_FILL, MODE_CLEAR: state_d = ST_FILL;
            MODE_INVERT:           state_d = ST_INV_RD;
            default:               state_d = ST_FIN;
          endcase
        end
      end
      ST_FILL: begin
        busy_c = 1'b1;
        eng_we = 1'b1;
        step   = 1'b1;
        if (last) state_d = ST_FIN;
      end
      ST_INV_RD: begin
        busy_c  = 1'b1;
        state_d = ST_INV_WR;
      end
      ST_INV_WR: begin
        busy_c  = 1'b1;
        eng_we  = 1'b1;
        eng_wd  = ~FB_RD;
        step    = 1'b1;
        state_d = last ? ST_FIN : ST_INV_RD;
      end
      ST_FIN: begin
        done_c  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Port mux: engine while busy, MCU otherwise (MCU writes dropped while busy)
  always_comb begin
    if (busy_c) begin
      FB_WA = fb_addr(cur_row, cur_col);
      FB_WD = eng_wd;
      FB_WE = eng_we;
    end else begin
      FB_WA = MCU_WA;
      FB_WD = MCU_WD;
      FB_WE = MCU_WE;
    end
  end

  assign BUSY   = busy_c;
  assign DONE   = done_c;
  assign MCU_RD = FB_RD;

endmodule

// File: tb/tb_vga_rect_engine.sv
// Scoreboarded bench for vga_rect_engine with a behavioural framebuffer.
module tb_vga_rect_engine;

  localparam logic [1:0] K_WR   = 2'd0;
  localparam logic [1:0] K_RD   = 2'd1;
  localparam logic [1:0] K_DONE = 2'd2;

  typedef struct {
    logic [1:0]  kind;
    int          cyc;
    logic [12:0] addr;
    logic [7:0]  data;
  } exp_t;

  logic        CLK = 1'b0;
  logic        RST;
  logic [12:0] MCU_WA;
  logic [7:0]  MCU_WD;
  logic        MCU_WE;
  logic [7:0]  MCU_RD;
  logic [6:0]  X0, X1;
  logic [5:0]  Y0, Y1;
  logic [7:0]  COLOR;
  logic [1:0]  MODE;
  logic        START;
  logic        BUSY, DONE;
  logic [12:0] FB_WA;
  logic [7:0]  FB_WD;
  logic        FB_WE;
  logic [7:0]  FB_RD;

  logic [7:0]  fbmem [0:8191];
  exp_t        q[$];
  int          cyc = 0;
  int          vecs = 0;
  int          errs = 0;
  bit          mon_en = 1'b0;

  vga_rect_engine dut (
    .CLK(CLK), .RST(RST),
    .MCU_WA(MCU_WA), .MCU_WD(MCU_WD), .MCU_WE(MCU_WE), .MCU_RD(MCU_RD),
    .X0(X0), .X1(X1), .Y0(Y0), .Y1(Y1),
    .COLOR(COLOR), .MODE(MODE), .START(START),
    .BUSY(BUSY), .DONE(DONE),
    .FB_WA(FB_WA), .FB_WD(FB_WD), .FB_WE(FB_WE), .FB_RD(FB_RD)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Framebuffer: synchronous write, read data one cycle after address
  always @(posedge CLK) begin
    if (FB_WE) fbmem[FB_WA] <= FB_WD;
    FB_RD <= fbmem[FB_WA];
  end

  // Monitor: passthrough checks when idle, scoreboard pops on engine events
  always @(negedge CLK) begin
    if (mon_en) begin
      exp_t        e;
      logic [1:0]  kind;
      vecs++;
      if (MCU_RD !== FB_RD) begin
        errs++;
        $display("FAIL mcu_rd cyc=%0d got=%h want=%h", cyc, MCU_RD, FB_RD);
      end
      if (!BUSY) begin
        vecs++;
        if (FB_WE !== MCU_WE || FB_WA !== MCU_WA || FB_WD !== MCU_WD) begin
          errs++;
          $display("FAIL passthru cyc=%0d got we=%b wa=%0d wd=%h want we=%b wa=%0d wd=%h",
                   cyc, FB_WE, FB_WA, FB_WD, MCU_WE, MCU_WA, MCU_WD);
        end
      end
      if (BUSY || DONE) begin
        kind = DONE ? K_DONE : (FB_WE ? K_WR : K_RD);
        vecs++;
        if (BUSY && DONE) begin
          errs++;
          $display("FAIL busy_done_overlap cyc=%0d got busy=1 done=1 want exclusive", cyc);
        end else if (q.size() == 0) begin
          errs++;
          $display("FAIL unexpected_event cyc=%0d got kind=%0d wa=%0d wd=%h want none",
                   cyc, kind, FB_WA, FB_WD);
        end else begin
          e = q.pop_front();
          if (kind !== e.kind || cyc != e.cyc ||
              (e.kind != K_DONE && FB_WA !== e.addr) ||
              (e.kind == K_WR && FB_WD !== e.data)) begin
            errs++;
            $display("FAIL event cyc=%0d got kind=%0d wa=%0d wd=%h want kind=%0d cyc=%0d wa=%0d wd=%h",
                     cyc, kind, FB_WA, FB_WD, e.kind, e.cyc, e.addr, e.data);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input logic [1:0] k, input int c, input int a, input logic [7:0] d);
    exp_t e;
    e.kind = k;
    e.cyc  = c;
    e.addr = 13'(a);
    e.data = d;
    q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    vecs++;
    if (got !== want) begin
      errs++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  // Drive a START for one cycle; s = cycle in which START is sampled
  task automatic start_op(input logic [1:0] m, input int x0, input int x1,
                          input int y0, input int y1, input logic [7:0] c,
                          output int s);
    MODE  = m;
    X0    = 7'(x0);
    X1    = 7'(x1);
    Y0    = 6'(y0);
    Y1    = 6'(y1);
    COLOR = c;
    START = 1'b1;
    s     = cyc;
    tick();
    START = 1'b0;
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while (q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    vecs++;
    if (q.size() != 0) begin
      errs++;
      $display("FAIL %s_timeout got pending=%0d want 0", name, q.size());
      q.delete();
    end
    tick();
    tick();
  endtask

  initial begin
    int s;
    for (int i = 0; i < 8192; i++) fbmem[i] = 8'h00;
    RST = 1'b1; MCU_WA = '0; MCU_WD = '0; MCU_WE = 1'b0;
    X0 = '0; X1 = '0; Y0 = '0; Y1 = '0; COLOR = '0; MODE = '0; START = 1'b0;
    repeat (3) tick();
    RST = 1'b0;
    tick();
    chk("reset_busy", 32'(BUSY), 0);
    chk("reset_done", 32'(DONE), 0);
    mon_en = 1'b1;
    tick();

    // Basic fill (3,4)-(4,5)
    start_op(2'b00, 3, 4, 4, 5, 8'hE0, s);
    push(K_WR, s+1, 515, 8'hE0);
    push(K_WR, s+2, 516, 8'hE0);
    push(K_WR, s+3, 643, 8'hE0);
    push(K_WR, s+4, 644, 8'hE0);
    push(K_DONE, s+5, 0, 8'h00);
    drain("fill", 20);

    // Swapped corners; START during BUSY must be ignored
    start_op(2'b00, 4, 3, 5, 4, 8'hE0, s);
    push(K_WR, s+1, 515, 8'hE0);
    push(K_WR, s+2, 516, 8'hE0);
    push(K_WR, s+3, 643, 8'hE0);
    push(K_WR, s+4, 644, 8'hE0);
    push(K_DONE, s+5, 0, 8'h00);
    tick();
    MODE = 2'b10; COLOR = 8'h11; START = 1'b1;
    tick();
    START = 1'b0;
    drain("fill_swap", 20);

    // Reserved mode: DONE next cycle, no writes
    start_op(2'b11, 1, 2, 1, 2, 8'hAA, s);
    push(K_DONE, s+1, 0, 8'h00);
    drain("rsvd", 10);

    // Preload pixel (10,2) through passthrough, then invert it with MCU writes attempted
    MCU_WA = 13'd266; MCU_WD = 8'h1C; MCU_WE = 1'b1;
    tick();
    MCU_WE = 1'b0;
    tick();
    start_op(2'b01, 10, 10, 2, 2, 8'h00, s);
    push(K_RD, s+1, 266, 8'h00);
    push(K_WR, s+2, 266, 8'hE3);
    push(K_DONE, s+3, 0, 8'h00);
    MCU_WA = 13'd266; MCU_WD = 8'hFF; MCU_WE = 1'b1;
    tick();
    tick();
    MCU_WE = 1'b0;
    drain("invert1", 10);
    chk("invert1_mem", 32'(fbmem[266]), 32'h0000_00E3);

    // Clamp: only cols 78-79, rows 58-59
    start_op(2'b00, 78, 100, 58, 63, 8'h1C, s);
    push(K_WR, s+1, 7502, 8'h1C);
    push(K_WR, s+2, 7503, 8'h1C);
    push(K_WR, s+3, 7630, 8'h1C);
    push(K_WR, s+4, 7631, 8'h1C);
    push(K_DONE, s+5, 0, 8'h00);
    drain("clamp", 20);

    // Full clear: 4800 writes, coordinates ignored
    start_op(2'b10, 5, 6, 7, 8, 8'h03, s);
    for (int r = 0; r < 60; r++)
      for (int c = 0; c < 80; c++)
        push(K_WR, s+1+r*80+c, r*128+c, 8'h03);
    push(K_DONE, s+4801, 0, 8'h00);
    drain("clear", 5000);

    // Invert 2x2 over cleared screen: 03 -> FC
    start_op(2'b01, 5, 6, 6, 7, 8'h00, s);
    push(K_RD, s+1, 773, 8'h00);  push(K_WR, s+2, 773, 8'hFC);
    push(K_RD, s+3, 774, 8'h00);  push(K_WR, s+4, 774, 8'hFC);
    push(K_RD, s+5, 901, 8'h00);  push(K_WR, s+6, 901, 8'hFC);
    push(K_RD, s+7, 902, 8'h00);  push(K_WR, s+8, 902, 8'hFC);
    push(K_DONE, s+9, 0, 8'h00);
    drain("invert4", 30);

    // Reset in cycle 3 of a FILL: abort, passthrough from cycle 4, no DONE
    start_op(2'b00, 0, 9, 1, 1, 8'h1F, s);
    push(K_WR, s+1, 128, 8'h1F);
    push(K_WR, s+2, 129, 8'h1F);
    push(K_WR, s+3, 130, 8'h1F);
    tick();
    tick();
    RST = 1'b1; MCU_WA = 13'd4000; MCU_WD = 8'h55; MCU_WE = 1'b1;
    tick();
    RST = 1'b0;
    chk("rst_abort_busy", 32'(BUSY), 0);
    chk("rst_abort_done", 32'(DONE), 0);
    chk("rst_abort_we", 32'(FB_WE), 1);
    chk("rst_abort_wa", 32'(FB_WA), 4000);
    tick();
    MCU_WE = 1'b0;
    repeat (12) tick();
    chk("rst_abort_pending", 32'(q.size()), 0);
    chk("rst_abort_mem", 32'(fbmem[131]), 32'h0000_0003);

    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
